divisor_programable: RTL and testbench

//  Multi-channel programmable clock divider / tick generator. Replaces fixed single-ratio dividers.

---
 rtl/divisor_programable.sv | 95 +++++++++
 tb/tb_divisor_programable.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divisor_programable.sv
`default_nettype none
// ============================================================================
// Module      : divisor_programable
// Description : Multi-channel programmable clock divider / tick generator.
//               Each channel counts 0..Limite and, on reaching Limite,
//               toggles its square wave Frec[i] and pulses Tick[i].
//               Limite is run-time writable per channel.
//               Optional macro DIVISOR_SINCRONIA_EN adds a Sincroniza input
//               that phase-aligns every channel (cont/Frec/Tick cleared).
// Revision    : 1.0 - initial release
// ============================================================================
module divisor_programable #(
  parameter  int CANALES        = 4,
  parameter  int ANCHO          = 16,
  parameter  int LIMITE_INICIAL = 24999,
  localparam int CW             = (CANALES > 1) ? $clog2(CANALES) : 1
) (
  input  logic               Reloj,
  input  logic               Reset_n,
  input  logic [CANALES-1:0] Habilita,
  input  logic               Escribe,
  input  logic [CW-1:0]      Canal,
  input  logic [ANCHO-1:0]   Dato,
`ifdef DIVISOR_SINCRONIA_EN
  input  logic               Sincroniza,
`endif
  output logic [CANALES-1:0] Frec,
  output logic [CANALES-1:0] Tick
);

  localparam logic [ANCHO-1:0] c_limite_ini = LIMITE_INICIAL[ANCHO-1:0];

  for (genvar i = 0; i < CANALES; i++) begin : g_canal
    logic [ANCHO-1:0] limite_q, limite_d;
    logic [ANCHO-1:0] cont_q, cont_d;
    logic             frec_q, frec_d;
    logic             tick_q, tick_d;
    logic             wr_hit;

    // An out-of-range Canal matches no channel, so such writes vanish here.
    assign wr_hit = Escribe && (32'(Canal) == i);

    // Next-state: count/toggle when enabled, then a write overrides the count.
    always_comb begin
      limite_d = limite_q;
      cont_d   = cont_q;
      frec_d   = frec_q;
      tick_d   = 1'b0;
      if (Habilita[i]) begin
        if (cont_q == limite_q) begin
          cont_d = '0;
          frec_d = ~frec_q;
          tick_d = 1'b1;
        end else begin
          cont_d = cont_q + 1'b1;
        end
      end
      // A write beats a coincident terminal count: no toggle, no tick.
      if (wr_hit) begin
        limite_d = Dato;
        cont_d   = '0;
        frec_d   = frec_q;
        tick_d   = 1'b0;
      end
`ifdef DIVISOR_SINCRONIA_EN
      // Alignment wins for the counting state; a coincident Limite write still lands.
      if (Sincroniza) begin
        cont_d = '0;
        frec_d = 1'b0;
        tick_d = 1'b0;
      end
`endif
    end

    // Channel state registers with asynchronous reset.
    always_ff @(posedge Reloj or negedge Reset_n) begin
      if (!Reset_n) begin
        limite_q <= c_limite_ini;
        cont_q   <= '0;
        frec_q   <= 1'b0;
        tick_q   <= 1'b0;
      end else begin
        limite_q <= limite_d;
        cont_q   <= cont_d;
        frec_q   <= frec_d;
        tick_q   <= tick_d;
      end
    end

    assign Frec[i] = frec_q;
    assign Tick[i] = tick_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_divisor_programable.sv
`default_nettype none
// ============================================================================
// Module      : tb_divisor_programable
// Description : Directed self-checking bench for divisor_programable.
//               Instance A: 4 channels, default limits. Instance B: 3
//               channels, limit 3, used for out-of-range channel writes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_divisor_programable;

  logic        clk;
  logic        rst_n;
  logic [3:0]  hab;
  logic        esc;
  logic [1:0]  canal;
  logic [15:0] dato;
  logic [3:0]  frec;
  logic [3:0]  tick;

  logic [2:0]  hab_b;
  logic        esc_b;
  logic [1:0]  canal_b;
  logic [7:0]  dato_b;
  logic [2:0]  frec_b;
  logic [2:0]  tick_b;
`ifdef DIVISOR_SINCRONIA_EN
  logic        sinc;
`endif

  int n_cmp;
  int n_err;
  int ciclo;

  divisor_programable dut_a (
    .Reloj    (clk),
    .Reset_n  (rst_n),
    .Habilita (hab),
    .Escribe  (esc),
    .Canal    (canal),
    .Dato     (dato),
`ifdef DIVISOR_SINCRONIA_EN
    .Sincroniza (sinc),
`endif
    .Frec     (frec),
    .Tick     (tick)
  );

  divisor_programable #(.CANALES(3), .ANCHO(8), .LIMITE_INICIAL(3)) dut_b (
    .Reloj    (clk),
    .Reset_n  (rst_n),
    .Habilita (hab_b),
    .Escribe  (esc_b),
    .Canal    (canal_b),
    .Dato     (dato_b),
`ifdef DIVISOR_SINCRONIA_EN
    .Sincroniza (1'b0),
`endif
    .Frec     (frec_b),
    .Tick     (tick_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising edges since reset release; instance B runs free from release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ciclo <= 0;
    else        ciclo <= ciclo + 1;
  end

  task automatic test_reset;
    rst_n = 1'b0; hab = 4'hF; esc = 1'b0; canal = '0; dato = '0;
    hab_b = 3'b111; esc_b = 1'b0; canal_b = '0; dato_b = '0;
`ifdef DIVISOR_SINCRONIA_EN
    sinc = 1'b0;
`endif
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({frec, tick} !== 8'h00) begin
      n_err++; $display("FAIL reset_a: got %b expected 00000000", {frec, tick});
    end
    n_cmp++;
    if ({frec_b, tick_b} !== 6'b0) begin
      n_err++; $display("FAIL reset_b: got %b expected 000000", {frec_b, tick_b});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_default_period;
    repeat (24999) @(negedge clk);
    n_cmp++;
    if ({frec, tick} !== 8'h00) begin
      n_err++; $display("FAIL dflt_before_rise: got %b expected 00000000", {frec, tick});
    end
    @(negedge clk);
    n_cmp++;
    if ({frec, tick} !== 8'hFF) begin
      n_err++; $display("FAIL dflt_first_rise: got %b expected 11111111", {frec, tick});
    end
    @(negedge clk);
    n_cmp++;
    if ({frec, tick} !== 8'hF0) begin
      n_err++; $display("FAIL dflt_tick_clear: got %b expected 11110000", {frec, tick});
    end
    repeat (24998) @(negedge clk);
    n_cmp++;
    if ({frec, tick} !== 8'hF0) begin
      n_err++; $display("FAIL dflt_before_fall: got %b expected 11110000", {frec, tick});
    end
    @(negedge clk);
    n_cmp++;
    if ({frec, tick} !== 8'h0F) begin
      n_err++; $display("FAIL dflt_fall: got %b expected 00001111", {frec, tick});
    end
  endtask

  task automatic test_write_period;
    logic [3:0] et, ef;
    esc = 1'b1; canal = 2'd1; dato = 16'd3;
    @(negedge clk);
    esc = 1'b0;
    n_cmp++;
    if ({frec, tick} !== 8'h00) begin
      n_err++; $display("FAIL wr1_edge: got %b expected 00000000", {frec, tick});
    end
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      et = ((k % 4) == 0) ? 4'b0010 : 4'b0000;
      ef = (((k / 4) % 2) == 1) ? 4'b0010 : 4'b0000;
      n_cmp++;
      if ({frec, tick} !== {ef, et}) begin
        n_err++; $display("FAIL wr1_period k=%0d: got %b expected %b", k, {frec, tick}, {ef, et});
      end
    end
  endtask

  task automatic test_limite_cero;
    esc = 1'b1; canal = 2'd2; dato = 16'd0;
    @(negedge clk);
    esc = 1'b0;
    n_cmp++;
    if ({frec[2], tick[2]} !== 2'b00) begin
      n_err++; $display("FAIL lim0_edge: got %b expected 00", {frec[2], tick[2]});
    end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({frec[2], tick[2]} !== {k[0], 1'b1}) begin
        n_err++; $display("FAIL lim0_toggle k=%0d: got %b expected %b", k, {frec[2], tick[2]}, {k[0], 1'b1});
      end
    end
  endtask

  task automatic test_habilita;
    int bad;
    logic [1:0] e;
    esc = 1'b1; canal = 2'd0; dato = 16'd20;
    @(negedge clk);
    esc = 1'b0;
    repeat (10) @(negedge clk);
    hab[0] = 1'b0;
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if ({frec[0], tick[0]} !== 2'b00) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++; $display("FAIL hab_frozen: got %0d bad cycles expected 0", bad);
    end
    hab[0] = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      e = (k == 11) ? 2'b11 : 2'b00;
      n_cmp++;
      if ({frec[0], tick[0]} !== e) begin
        n_err++; $display("FAIL hab_resume k=%0d: got %b expected %b", k, {frec[0], tick[0]}, e);
      end
    end
  endtask

  task automatic test_write_at_terminal;
    logic [1:0] e;
    esc = 1'b1; canal = 2'd0; dato = 16'd5;
    @(negedge clk);
    esc = 1'b0;
    repeat (5) @(negedge clk);
    esc = 1'b1; canal = 2'd0; dato = 16'd5;
    @(negedge clk);
    esc = 1'b0;
    n_cmp++;
    if ({frec[0], tick[0]} !== 2'b10) begin
      n_err++; $display("FAIL wr_term_no_toggle: got %b expected 10", {frec[0], tick[0]});
    end
    n_cmp++;
    if ({frec[3], tick[3]} !== 2'b00) begin
      n_err++; $display("FAIL wr_term_other_ch: got %b expected 00", {frec[3], tick[3]});
    end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      e = (k == 6) ? 2'b01 : 2'b10;
      n_cmp++;
      if ({frec[0], tick[0]} !== e) begin
        n_err++; $display("FAIL wr_term_restart k=%0d: got %b expected %b", k, {frec[0], tick[0]}, e);
      end
    end
  endtask

  task automatic test_write_disabled;
    logic [1:0] e;
    hab[3] = 1'b0;
    @(negedge clk);
    esc = 1'b1; canal = 2'd3; dato = 16'd1;
    @(negedge clk);
    esc = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({frec[3], tick[3]} !== 2'b00) begin
      n_err++; $display("FAIL wr_dis_hold: got %b expected 00", {frec[3], tick[3]});
    end
    hab[3] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      e = {(k == 2 || k == 3), (k % 2 == 0)};
      n_cmp++;
      if ({frec[3], tick[3]} !== e) begin
        n_err++; $display("FAIL wr_dis_run k=%0d: got %b expected %b", k, {frec[3], tick[3]}, e);
      end
    end
  endtask

  task automatic test_out_of_range;
    logic [2:0] et, ef;
    esc_b = 1'b1; canal_b = 2'd3; dato_b = 8'd0;
    @(negedge clk);
    esc_b = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      et = ((ciclo % 4) == 0) ? 3'b111 : 3'b000;
      ef = (((ciclo / 4) % 2) == 1) ? 3'b111 : 3'b000;
      n_cmp++;
      if ({frec_b, tick_b} !== {ef, et}) begin
        n_err++; $display("FAIL oor_write k=%0d: got %b expected %b", k, {frec_b, tick_b}, {ef, et});
      end
    end
  endtask

`ifdef DIVISOR_SINCRONIA_EN
  task automatic test_sincroniza;
    sinc = 1'b1;
    @(negedge clk);
    sinc = 1'b0;
    n_cmp++;
    if ({frec, tick} !== 8'h00) begin
      n_err++; $display("FAIL sync_clear: got %b expected 00000000", {frec, tick});
    end
    @(negedge clk);
    n_cmp++;
    if ({frec[2], tick[2]} !== 2'b11) begin
      n_err++; $display("FAIL sync_lim0: got %b expected 11", {frec[2], tick[2]});
    end
  endtask
`endif

  task automatic test_async_reset;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({frec, tick, frec_b, tick_b} !== 14'b0) begin
      n_err++; $display("FAIL async_reset: got %b expected 0", {frec, tick, frec_b, tick_b});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    n_cmp++;
    if ({frec, tick} !== 8'h00) begin
      n_err++; $display("FAIL reset_limits_a: got %b expected 00000000", {frec, tick});
    end
    n_cmp++;
    if ({frec_b, tick_b} !== 6'b000111) begin
      n_err++; $display("FAIL reset_limits_b: got %b expected 000111", {frec_b, tick_b});
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_default_period();
    test_write_period();
    test_limite_cero();
    test_habilita();
    test_write_at_terminal();
    test_write_disabled();
    test_out_of_range();
`ifdef DIVISOR_SINCRONIA_EN
    test_sincroniza();
`endif
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
